fwu_frame_rx: RTL and testbench

Firmware-update frame receiver: parses the byte stream delivered by the SLIP decoder into framed commands, checks the fixed header and the trailing CRC-32, and forwards header fields and payload to the command handler. It is the host-to-device counterpart of the response frame transmitter and uses the same frame format: `55 AA 01 type seq[15:8] seq[7:0] len[15:8] len[7:0] payload[len] crc[31:24] .. crc[7:0]`. Payload is streamed through without buffering, so the handler must act on it only when the final status is OK.

---
 rtl/fwu_frame_rx.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_fwu_frame_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwu_frame_rx.sv
// Firmware-update frame receiver.
// Parses the SLIP-decoded byte stream into framed commands:
//   55 AA 01 type seq[15:8] seq[7:0] len[15:8] len[7:0] payload[len] crc[31:24..7:0]
// The header and payload are covered by a reflected CRC-32 (IEEE). The payload is
// streamed straight to the handler without buffering, so the handler must only
// act on it once rx_done reports OK.

// Byte-serial CRC-32 (IEEE 802.3, reflected, poly 0xEDB88320).
// Holds the raw running state. The final CRC value is ~crc_state.
module crc32_ieee (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_state
);

    // One reflected CRC-32 step over a whole byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic [31:0] crc_r;

    // Running CRC state: preset on reset or init, advanced one byte per enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 32'hFFFF_FFFF;
        end else if (init) begin
            crc_r <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc_r <= crc32_byte(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_state = crc_r;

endmodule

module fwu_frame_rx #(
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slip_start,
    input  logic        slip_end,
    input  logic [7:0]  slip_data,
    input  logic        slip_valid,
    output logic        slip_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_seq,
    output logic [15:0] cmd_len,
    output logic [7:0]  cmd_data,
    output logic        cmd_data_valid,
    input  logic        cmd_data_ready,
    output logic        rx_done,
    output logic [2:0]  rx_status
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_HOLD    = 3'd2,
        S_PAY     = 3'd3,
        S_CRC     = 3'd4,
        S_TAIL    = 3'd5,
        S_DISCARD = 3'd6
    } state_t;

    localparam logic [2:0]  ST_OK      = 3'd0;
    localparam logic [2:0]  ST_BAD_HDR = 3'd1;
    localparam logic [2:0]  ST_BAD_LEN = 3'd2;
    localparam logic [2:0]  ST_SHORT   = 3'd3;
    localparam logic [2:0]  ST_LONG    = 3'd4;
    localparam logic [2:0]  ST_BAD_CRC = 3'd5;
    localparam logic [2:0]  ST_ABORT   = 3'd6;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    // Fixed sync/version bytes expected at header positions 0..2.
    function automatic logic [7:0] hdr_magic(input logic [2:0] idx);
        logic [7:0] m;
        case (idx)
            3'd0:    m = 8'h55;
            3'd1:    m = 8'hAA;
            default: m = 8'h01;
        endcase
        return m;
    endfunction

    // Registers
    state_t      state_r;
    logic [2:0]  idx_r;
    logic [15:0] cnt_r;
    logic [31:0] rx_crc_r;
    logic [2:0]  err_r;
    logic [7:0]  type_r;
    logic [15:0] seq_r;
    logic [15:0] len_r;
    logic        rx_done_r;
    logic [2:0]  rx_status_r;

    // Combinational controls
    state_t      state_s;
    logic        ready_s;
    logic        acc_s;
    logic        crc_init_s;
    logic        crc_init_in_s;
    logic        crc_en_s;
    logic        done_s;
    logic [2:0]  status_s;
    logic        err_ld_s;
    logic [2:0]  err_val_s;
    logic        hdr_ld_s;
    logic        pay_xfer_s;
    logic        crc_shift_s;
    logic [15:0] cnt_next_s;
    logic [31:0] crc_state_s;

    // CRC engine is held in its preset state while reset is asserted.
    assign crc_init_in_s = crc_init_s | ~rst_n;

    crc32_ieee u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (crc_init_in_s),
        .en        (crc_en_s),
        .data      (slip_data),
        .crc_state (crc_state_s)
    );

    // Input-side backpressure per state; payload ready passes straight through.
    always_comb begin
        ready_s = 1'b1;
        case (state_r)
            S_HOLD:  ready_s = 1'b0;
            S_PAY:   ready_s = cmd_data_ready;
            default: ready_s = 1'b1;
        endcase
    end

    assign acc_s      = slip_valid & ready_s;
    assign cnt_next_s = cnt_r + 16'd1;

    // Next-state and per-cycle controls; slip_start outranks slip_end, which outranks a byte.
    always_comb begin
        state_s     = state_r;
        crc_init_s  = 1'b0;
        crc_en_s    = 1'b0;
        done_s      = 1'b0;
        status_s    = ST_OK;
        err_ld_s    = 1'b0;
        err_val_s   = ST_OK;
        hdr_ld_s    = 1'b0;
        pay_xfer_s  = 1'b0;
        crc_shift_s = 1'b0;
        if (slip_start) begin
            crc_init_s = 1'b1;
            state_s    = S_HDR;
            if (state_r != S_IDLE) begin
                done_s   = 1'b1;
                status_s = ST_ABORT;
            end else begin
                done_s   = 1'b0;
            end
        end else if (slip_end) begin
            case (state_r)
                S_HDR, S_HOLD, S_PAY, S_CRC: begin
                    done_s   = 1'b1;
                    status_s = ST_SHORT;
                    state_s  = S_IDLE;
                end
                S_TAIL: begin
                    done_s   = 1'b1;
                    status_s = (rx_crc_r == ~crc_state_s) ? ST_OK : ST_BAD_CRC;
                    state_s  = S_IDLE;
                end
                S_DISCARD: begin
                    done_s   = 1'b1;
                    status_s = err_r;
                    state_s  = S_IDLE;
                end
                default: begin
                    state_s  = S_IDLE;
                end
            endcase
        end else if (acc_s) begin
            case (state_r)
                S_HDR: begin
                    crc_en_s = 1'b1;
                    hdr_ld_s = 1'b1;
                    if ((idx_r < 3'd3) && (slip_data != hdr_magic(idx_r))) begin
                        err_ld_s  = 1'b1;
                        err_val_s = ST_BAD_HDR;
                        state_s   = S_DISCARD;
                    end else if (idx_r == 3'd7) begin
                        if ({len_r[15:8], slip_data} > MAX_LEN) begin
                            err_ld_s  = 1'b1;
                            err_val_s = ST_BAD_LEN;
                            state_s   = S_DISCARD;
                        end else begin
                            state_s   = S_HOLD;
                        end
                    end else begin
                        state_s = S_HDR;
                    end
                end
                S_PAY: begin
                    crc_en_s   = 1'b1;
                    pay_xfer_s = 1'b1;
                    if (cnt_next_s == len_r) begin
                        state_s = S_CRC;
                    end else begin
                        state_s = S_PAY;
                    end
                end
                S_CRC: begin
                    crc_shift_s = 1'b1;
                    if (idx_r == 3'd3) begin
                        state_s = S_TAIL;
                    end else begin
                        state_s = S_CRC;
                    end
                end
                S_TAIL: begin
                    err_ld_s  = 1'b1;
                    err_val_s = ST_LONG;
                    state_s   = S_DISCARD;
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else if ((state_r == S_HOLD) && cmd_ready) begin
            if (len_r == 16'd0) begin
                state_s = S_CRC;
            end else begin
                state_s = S_PAY;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Header/CRC byte index and payload byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 3'd0;
            cnt_r <= 16'd0;
        end else begin
            if (crc_init_s || (state_s != state_r)) begin
                idx_r <= 3'd0;
            end else if (hdr_ld_s || crc_shift_s) begin
                idx_r <= idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (crc_init_s) begin
                cnt_r <= 16'd0;
            end else if (pay_xfer_s) begin
                cnt_r <= cnt_next_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Header field capture; fields stay stable from HOLD onwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_r <= 8'd0;
            seq_r  <= 16'd0;
            len_r  <= 16'd0;
        end else if (hdr_ld_s) begin
            case (idx_r)
                3'd3:    type_r       <= slip_data;
                3'd4:    seq_r[15:8]  <= slip_data;
                3'd5:    seq_r[7:0]   <= slip_data;
                3'd6:    len_r[15:8]  <= slip_data;
                3'd7:    len_r[7:0]   <= slip_data;
                default: type_r       <= type_r;
            endcase
        end else begin
            type_r <= type_r;
        end
    end

    // Received CRC, shifted in MSB first, and the latched discard reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_crc_r <= 32'd0;
            err_r    <= ST_OK;
        end else begin
            if (crc_shift_s) begin
                rx_crc_r <= {rx_crc_r[23:0], slip_data};
            end else begin
                rx_crc_r <= rx_crc_r;
            end
            if (err_ld_s) begin
                err_r <= err_val_s;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Registered completion pulse; status holds until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_r   <= 1'b0;
            rx_status_r <= ST_OK;
        end else begin
            rx_done_r <= done_s;
            if (done_s) begin
                rx_status_r <= status_s;
            end else begin
                rx_status_r <= rx_status_r;
            end
        end
    end

    assign slip_ready     = ready_s;
    assign cmd_valid      = (state_r == S_HOLD);
    assign cmd_type       = type_r;
    assign cmd_seq        = seq_r;
    assign cmd_len        = len_r;
    assign cmd_data       = slip_data;
    assign cmd_data_valid = (state_r == S_PAY) ? slip_valid : 1'b0;
    assign rx_done        = rx_done_r;
    assign rx_status      = rx_status_r;

endmodule

// File: tb/tb_fwu_frame_rx.sv
// Directed testbench for fwu_frame_rx: builds frames with a golden CRC-32,
// drives them byte by byte and checks header fields, payload stream and status.
module tb_fwu_frame_rx;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        slip_start     = 1'b0;
    logic        slip_end       = 1'b0;
    logic [7:0]  slip_data      = 8'h00;
    logic        slip_valid     = 1'b0;
    logic        cmd_ready      = 1'b1;
    logic        cmd_data_ready = 1'b1;
    logic        slip_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_seq;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_data;
    logic        cmd_data_valid;
    logic        rx_done;
    logic [2:0]  rx_status;

    int checks = 0;
    int errors = 0;

    logic [7:0] frm[$];
    logic [7:0] pay_q[$];
    int         hdr_acc  = 0;
    int         done_cnt = 0;
    int         hdr_before;

    fwu_frame_rx #(.MAX_PAYLOAD(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .slip_start     (slip_start),
        .slip_end       (slip_end),
        .slip_data      (slip_data),
        .slip_valid     (slip_valid),
        .slip_ready     (slip_ready),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_type       (cmd_type),
        .cmd_seq        (cmd_seq),
        .cmd_len        (cmd_len),
        .cmd_data       (cmd_data),
        .cmd_data_valid (cmd_data_valid),
        .cmd_data_ready (cmd_data_ready),
        .rx_done        (rx_done),
        .rx_status      (rx_status)
    );

    always #5 clk = ~clk;

    // Observe transfers mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (cmd_data_valid && cmd_data_ready) pay_q.push_back(cmd_data);
        if (cmd_valid && cmd_ready) hdr_acc++;
        if (rx_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mk_hdr(input logic [7:0] t, input logic [15:0] s, input logic [15:0] l);
        frm.delete();
        frm.push_back(8'h55);
        frm.push_back(8'hAA);
        frm.push_back(8'h01);
        frm.push_back(t);
        frm.push_back(s[15:8]);
        frm.push_back(s[7:0]);
        frm.push_back(l[15:8]);
        frm.push_back(l[7:0]);
    endtask

    // Golden CRC-32 over everything currently in frm, appended big-endian.
    task automatic add_crc(input logic [31:0] flip);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        c = ~c ^ flip;
        frm.push_back(c[31:24]);
        frm.push_back(c[23:16]);
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0]);
    endtask

    // Called and returns at posedge+1; waits (bounded) for slip_ready.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        slip_data  = b;
        slip_valid = 1'b1;
        #1;
        while (!slip_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("ready_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        slip_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_byte(frm[i]);
    endtask

    task automatic pulse_start();
        slip_start = 1'b1;
        @(posedge clk); #1;
        slip_start = 1'b0;
    endtask

    task automatic pulse_end();
        slip_end = 1'b1;
        @(posedge clk); #1;
        slip_end = 1'b0;
    endtask

    // One payload byte with cmd_data_ready low for a cycle, then high.
    task automatic pay_step(input logic [7:0] b);
        slip_data      = b;
        slip_valid     = 1'b1;
        cmd_data_ready = 1'b0;
        #1;
        check("pay_ready_lo", 32'(slip_ready), 32'd0);
        check("pay_data", 32'(cmd_data), 32'(b));
        check("pay_dvalid", 32'(cmd_data_valid), 32'd1);
        @(posedge clk); #1;
        cmd_data_ready = 1'b1;
        #1;
        check("pay_ready_hi", 32'(slip_ready), 32'd1);
        @(posedge clk); #1;
        slip_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [2:0] st);
        check({tag, "_done"}, 32'(rx_done), 32'd1);
        check({tag, "_status"}, 32'(rx_status), 32'(st));
    endtask

    initial begin
        logic [7:0] exp_pay [3];
        exp_pay[0] = 8'hDE;
        exp_pay[1] = 8'hAD;
        exp_pay[2] = 8'hBE;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_type", 32'(cmd_type), 32'd0);
        check("rst_cmd_seq", 32'(cmd_seq), 32'd0);
        check("rst_cmd_len", 32'(cmd_len), 32'd0);
        check("rst_dvalid", 32'(cmd_data_valid), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_rx_status", 32'(rx_status), 32'd0);
        check("rst_slip_ready", 32'(slip_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty-payload good frame
        mk_hdr(8'h10, 16'h0001, 16'h0000);
        add_crc(32'h0);
        pulse_start();
        check("t1_no_done_start", 32'(rx_done), 32'd0);
        send_range(0, 8);
        check("t1_cmd_valid", 32'(cmd_valid), 32'd1);
        check("t1_type", 32'(cmd_type), 32'h10);
        check("t1_seq", 32'(cmd_seq), 32'h0001);
        check("t1_len", 32'(cmd_len), 32'h0000);
        check("t1_hold_ready", 32'(slip_ready), 32'd0);
        send_range(8, 12);
        check("t1_no_done_early", 32'(rx_done), 32'd0);
        pulse_end();
        expect_done("t1", 3'd0);
        check("t1_no_payload", 32'(pay_q.size()), 32'd0);
        check("t1_hdr_acc", 32'(hdr_acc), 32'd1);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(rx_done), 32'd0);

        // Len 3 payload DE AD BE with toggling cmd_data_ready
        pay_q.delete();
        mk_hdr(8'h10, 16'h0001, 16'h0003);
        frm.push_back(8'hDE);
        frm.push_back(8'hAD);
        frm.push_back(8'hBE);
        add_crc(32'h0);
        pulse_start();
        send_range(0, 8);
        check("t2_len", 32'(cmd_len), 32'd3);
        @(posedge clk); #1;
        for (int i = 8; i < 11; i++) pay_step(frm[i]);
        send_range(11, 15);
        pulse_end();
        expect_done("t2", 3'd0);
        check("t2_pay_cnt", 32'(pay_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < pay_q.size(); k++) begin
            check("t2_pay_byte", 32'(pay_q[k]), 32'(exp_pay[k]));
        end

        // Corrupted last CRC byte
        pay_q.delete();
        mk_hdr(8'h10, 16'h0002, 16'h0003);
        frm.push_back(8'h01);
        frm.push_back(8'h02);
        frm.push_back(8'h03);
        add_crc(32'h0000_0001);
        pulse_start();
        send_range(0, 15);
        pulse_end();
        expect_done("t3", 3'd5);
        check("t3_pay_cnt", 32'(pay_q.size()), 32'd3);
        @(posedge clk); #1;
        check("t3_status_held", 32'(rx_status), 32'd5);
        check("t3_done_low", 32'(rx_done), 32'd0);

        // Bad second header byte
        hdr_before = hdr_acc;
        mk_hdr(8'h10, 16'h0001, 16'h0000);
        frm[1] = 8'hAB;
        add_crc(32'h0);
        pulse_start();
        send_range(0, 12);
        check("t4_no_valid", 32'(cmd_valid), 32'd0);
        check("t4_discard_ready", 32'(slip_ready), 32'd1);
        pulse_end();
        expect_done("t4", 3'd1);
        check("t4_hdr_acc", 32'(hdr_acc), 32'(hdr_before));

        // Length one above the limit
        mk_hdr(8'h10, 16'h0001, 16'd1025);
        pulse_start();
        send_range(0, 8);
        check("t4b_no_valid", 32'(cmd_valid), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        pulse_end();
        expect_done("t4b", 3'd2);
        check("t4b_hdr_acc", 32'(hdr_acc), 32'(hdr_before));

        // Frame ended after 2 of 3 payload bytes
        mk_hdr(8'h10, 16'h0003, 16'h0003);
        frm.push_back(8'h11);
        frm.push_back(8'h22);
        frm.push_back(8'h33);
        pulse_start();
        send_range(0, 10);
        pulse_end();
        expect_done("t5s", 3'd3);

        // Extra byte after the CRC
        mk_hdr(8'h10, 16'h0004, 16'h0000);
        add_crc(32'h0);
        pulse_start();
        send_range(0, 12);
        send_byte(8'h5A);
        check("t5l_no_done", 32'(rx_done), 32'd0);
        pulse_end();
        expect_done("t5l", 3'd4);

        // slip_start during payload, then a complete good frame
        mk_hdr(8'h10, 16'h0005, 16'h0003);
        frm.push_back(8'h44);
        frm.push_back(8'h55);
        frm.push_back(8'h66);
        pulse_start();
        send_range(0, 9);
        pulse_start();
        expect_done("t6a", 3'd6);
        pay_q.delete();
        mk_hdr(8'h20, 16'h0006, 16'h0001);
        frm.push_back(8'h7E);
        add_crc(32'h0);
        send_range(0, 13);
        pulse_end();
        expect_done("t6b", 3'd0);
        check("t6b_pay_cnt", 32'(pay_q.size()), 32'd1);
        if (pay_q.size() == 1) check("t6b_pay_byte", 32'(pay_q[0]), 32'h7E);

        // Handler stalls the header for 10 cycles
        mk_hdr(8'h22, 16'h1234, 16'h0000);
        add_crc(32'h0);
        cmd_ready = 1'b0;
        pulse_start();
        send_range(0, 8);
        for (int i = 0; i < 10; i++) begin
            check("t7_ready", 32'(slip_ready), 32'd0);
            check("t7_valid", 32'(cmd_valid), 32'd1);
            check("t7_type", 32'(cmd_type), 32'h22);
            check("t7_seq", 32'(cmd_seq), 32'h1234);
            check("t7_len", 32'(cmd_len), 32'h0000);
            @(posedge clk); #1;
        end
        cmd_ready = 1'b1;
        send_range(8, 12);
        pulse_end();
        expect_done("t7", 3'd0);

        @(posedge clk); #1;
        check("total_done", 32'(done_cnt), 32'd10);
        check("total_hdr_acc", 32'(hdr_acc), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
